// File: rtl/feature_row_reader.sv
// feature_row_reader: reads 8-bit feature pixels row by row from the feature-buffer FIFO
// and skips each row's 16-pixel alignment tail with push_bubble.
// Latency: start sampled at edge 0 -> fifo_rden in cycle 1 -> o_pix_valid in cycle 3.
// Throughput is 1 pixel/cycle, plus one BUBBLE cycle per row when the row is not 16-aligned.
// Backpressure: a 2-entry skid buffer. FIFO reads are throttled so that it never
// overflows, and o_pix_* hold steady while o_pix_valid && !i_pix_ready.
//
// Ports:
//   system_clk, rst_n (async, active-low)
//   start, cfg_row_width, cfg_row_num : frame command; accepted only when idle
//   busy, done                        : frame status; done is a one-cycle pulse
//   fifo_rden/fifo_rddata/fifo_empty  : FIFO 8-bit read port; data arrives the cycle after rden
//   fifo_push_bubble/fifo_bubble_num  : skip the unused tail of the row's last 128-bit word
//   o_pix_*/i_pix_ready               : ready/valid pixel stream with row/frame end tags
// Optional build macro FEATURE_ROW_READER_PAD_EN adds cfg_pad_en. When cfg_pad_en is set,
// each row is framed by a leading and a trailing 0x00 pixel.

module feature_row_reader #(
  parameter int MAX_W      = 10,
  parameter int OBUF_DEPTH = 2
) (
  input  logic             system_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAX_W-1:0] cfg_row_width,
  input  logic [MAX_W-1:0] cfg_row_num,
`ifdef FEATURE_ROW_READER_PAD_EN
  input  logic             cfg_pad_en,
`endif
  output logic             busy,
  output logic             done,
  output logic             fifo_rden,
  input  logic [7:0]       fifo_rddata,
  input  logic             fifo_empty,
  output logic             fifo_push_bubble,
  output logic [MAX_W-1:0] fifo_bubble_num,
  output logic             o_pix_valid,
  output logic [7:0]       o_pix_data,
  output logic             o_pix_last_col,
  output logic             o_pix_last_row,
  input  logic             i_pix_ready
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OW = $clog2(OBUF_DEPTH + 1);
  localparam logic [MAX_W-1:0] ONE = {{(MAX_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    READ,
    BUBBLE,
    DRAIN
`ifdef FEATURE_ROW_READER_PAD_EN
    ,
    PAD_L,
    PAD_R
`endif
  } state_t;

  state_t           state_q, state_d;
  state_t           row_start_st;   // first state of every row after the first one
  state_t           first_st;       // first state of the frame, taken from the live config

  logic [MAX_W-1:0] width_q, rows_q, pad_q, col_q, row_q;
  logic             pad_en_q;
  logic             inflight_q;     // a FIFO read was issued last cycle; its data is on fifo_rddata
  logic             tag_lc_q, tag_lr_q;

  logic [OW-1:0]    occ_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [9:0]       obuf_q [OBUF_DEPTH];

  logic             pop, space, col_last, row_last, frame_end, pipe_idle;
  logic             accept, finish, ins_vld, ins_lc, ins_lr, wr_en;
  logic [9:0]       wr_dat;
  logic [3:0]       pad4;
  logic [OW:0]      level;

  // Distance from the row width up to the next multiple of 16 (modulo 16).
  assign pad4 = 4'd0 - cfg_row_width[3:0];

`ifdef FEATURE_ROW_READER_PAD_EN
  assign row_start_st = pad_en_q ? PAD_L : READ;
  assign first_st     = cfg_pad_en ? PAD_L : READ;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_en_q <= 1'b0;
    end else if (accept) begin
      pad_en_q <= cfg_pad_en;
    end
  end
`else
  assign row_start_st = READ;
  assign first_st     = READ;
  assign pad_en_q     = 1'b0;
`endif

  assign o_pix_valid = (occ_q != '0);
  assign {o_pix_data, o_pix_last_col, o_pix_last_row} = obuf_q[rd_ptr_q];
  assign pop         = o_pix_valid && i_pix_ready;

  // Count the entries already held plus the read still in flight, minus this cycle's pop.
  // A new read (or pad insert) is allowed only while that total leaves a free slot.
  assign level     = {1'b0, occ_q} + (OW+1)'(inflight_q) - (OW+1)'(pop);
  assign space     = (level < (OW+1)'(OBUF_DEPTH));
  assign pipe_idle = (occ_q == '0) && !inflight_q;

  assign col_last  = (col_q == width_q - ONE);
  assign row_last  = (row_q == rows_q - ONE);
  // row_q has already advanced past the row just read, so this means the frame is complete.
  assign frame_end = (row_q == rows_q);

  always_comb begin
    state_d          = state_q;
    fifo_rden        = 1'b0;
    fifo_push_bubble = 1'b0;
    fifo_bubble_num  = '0;
    accept           = 1'b0;
    finish           = 1'b0;
    ins_vld          = 1'b0;
    ins_lc           = 1'b0;
    ins_lr           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (cfg_row_width == '0 || cfg_row_num == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = first_st;
          end
        end
      end
      READ: begin
        fifo_rden = !fifo_empty && space;
        if (fifo_rden && col_last) begin
`ifdef FEATURE_ROW_READER_PAD_EN
          if (pad_en_q) begin
            state_d = PAD_R;
          end else
`endif
          if (pad_q != '0) begin
            state_d = BUBBLE;
          end else if (row_last) begin
            state_d = DRAIN;
          end else begin
            state_d = READ;
          end
        end
      end
      BUBBLE: begin
        fifo_push_bubble = 1'b1;
        fifo_bubble_num  = pad_q;
        state_d          = frame_end ? DRAIN : row_start_st;
      end
`ifdef FEATURE_ROW_READER_PAD_EN
      PAD_L: begin
        if (space) begin
          ins_vld = 1'b1;
          ins_lr  = row_last;
          state_d = READ;
        end
      end
      PAD_R: begin
        // Wait until the row's FIFO pixels have left the skid buffer.
        // The trailing zero then carries the end-of-row tag.
        if (pipe_idle) begin
          ins_vld = 1'b1;
          ins_lc  = 1'b1;
          ins_lr  = frame_end;
          if (pad_q != '0) begin
            state_d = BUBBLE;
          end else if (frame_end) begin
            state_d = DRAIN;
          end else begin
            state_d = PAD_L;
          end
        end
      end
`endif
      DRAIN: begin
        if (pipe_idle) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      width_q    <= '0;
      rows_q     <= '0;
      pad_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      tag_lc_q   <= 1'b0;
      tag_lr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      done       <= finish;
      inflight_q <= fifo_rden;
      if (accept) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
      // Tags travel one cycle behind the read, lined up with fifo_rddata.
      if (fifo_rden) begin
        tag_lc_q <= col_last && !pad_en_q;
        tag_lr_q <= row_last;
      end
      if (accept) begin
        width_q <= cfg_row_width;
        rows_q  <= cfg_row_num;
        pad_q   <= {{(MAX_W-4){1'b0}}, pad4};
        col_q   <= '0;
        row_q   <= '0;
      end else if (fifo_rden) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + ONE;
        end else begin
          col_q <= col_q + ONE;
        end
      end
    end
  end

  // Skid buffer write: either returning FIFO data or an inserted pad pixel.
  // A pad pixel is inserted only when no read is in flight, so the two never collide.
  assign wr_en  = inflight_q || ins_vld;
  assign wr_dat = inflight_q ? {fifo_rddata, tag_lc_q, tag_lr_q} : {8'h00, ins_lc, ins_lr};

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_en) begin
        obuf_q[wr_ptr_q] <= wr_dat;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      occ_q <= occ_q + OW'(wr_en) - OW'(pop);
    end
  end

endmodule

// File: tb/tb_feature_row_reader.sv
module tb_feature_row_reader;

  logic       system_clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] cfg_row_width, cfg_row_num;
`ifdef FEATURE_ROW_READER_PAD_EN
  logic       cfg_pad_en;
`endif
  logic       busy, done, fifo_rden, fifo_empty, fifo_push_bubble;
  logic [7:0] fifo_rddata;
  logic [9:0] fifo_bubble_num;
  logic       o_pix_valid, o_pix_last_col, o_pix_last_row, i_pix_ready;
  logic [7:0] o_pix_data;

  always #5 system_clk = ~system_clk;

  feature_row_reader dut (
    .system_clk      (system_clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_row_width   (cfg_row_width),
    .cfg_row_num     (cfg_row_num),
`ifdef FEATURE_ROW_READER_PAD_EN
    .cfg_pad_en      (cfg_pad_en),
`endif
    .busy            (busy),
    .done            (done),
    .fifo_rden       (fifo_rden),
    .fifo_rddata     (fifo_rddata),
    .fifo_empty      (fifo_empty),
    .fifo_push_bubble(fifo_push_bubble),
    .fifo_bubble_num (fifo_bubble_num),
    .o_pix_valid     (o_pix_valid),
    .o_pix_data      (o_pix_data),
    .o_pix_last_col  (o_pix_last_col),
    .o_pix_last_row  (o_pix_last_row),
    .i_pix_ready     (i_pix_ready)
  );

  // Feature FIFO model: byte i holds value i[7:0]; registered read data; bubble skips ahead.
  logic [7:0]  fifo_mem [4096];
  int unsigned rd_ptr;
  int unsigned wr_cnt;
  logic        force_empty;

  assign fifo_empty = force_empty || (rd_ptr >= wr_cnt);

  always @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= 0;
      fifo_rddata <= 8'h00;
    end else if (fifo_rden) begin
      fifo_rddata <= fifo_mem[rd_ptr[11:0]];
      rd_ptr      <= rd_ptr + 1;
    end else if (fifo_push_bubble) begin
      rd_ptr <= rd_ptr + 32'(fifo_bubble_num);
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c1;
  int n_rden, n_bub, n_done, n_pop, first_pop, last_pop, done_cyc, exp_bub;
  logic [9:0] sb_q[$];
  logic       stall_prev = 1'b0;
  logic [9:0] stall_dat;

  always @(posedge system_clk) cyc <= cyc + 1;

  // Scoreboard and protocol monitor, sampled away from the active edge.
  always @(negedge system_clk) begin
    logic [9:0] got, exp;
    got = {o_pix_data, o_pix_last_col, o_pix_last_row};
    if (rst_n === 1'b1) begin
      if (fifo_rden) n_rden++;
      if (fifo_empty) begin
        total++;
        if (fifo_rden !== 1'b0) begin
          bad++;
          $display("FAIL rden_on_empty: rden=%b required 0 at cyc %0d", fifo_rden, cyc);
        end
      end
      if (fifo_push_bubble) begin
        n_bub++;
        total++;
        if (fifo_bubble_num !== 10'(exp_bub) || fifo_rden !== 1'b0) begin
          bad++;
          $display("FAIL bubble: num=%0d rden=%b required num=%0d rden=0", fifo_bubble_num, fifo_rden, exp_bub);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (stall_prev) begin
        total++;
        if (o_pix_valid !== 1'b1 || got !== stall_dat) begin
          bad++;
          $display("FAIL stall_hold: valid=%b dat=%h required valid=1 dat=%h", o_pix_valid, got, stall_dat);
        end
      end
      if (o_pix_valid && i_pix_ready) begin
        if (n_pop == 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL extra_pixel: got dat=%h required none", got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL pixel: got data=%h lc=%b lr=%b required data=%h lc=%b lr=%b",
                     got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
          end
        end
      end
      stall_prev = o_pix_valid && !i_pix_ready;
      stall_dat  = got;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Expected stream model: rows are stored at a 16-byte stride in the FIFO.
  task automatic push_frame(input int w, input int rows, input bit pe);
    int stride;
    stride = ((w + 15) / 16) * 16;
    for (int r = 0; r < rows; r++) begin
      if (pe && w > 0) sb_q.push_back({8'h00, 1'b0, r == rows - 1});
      for (int c = 0; c < w; c++) begin
        sb_q.push_back({8'(r * stride + c), (!pe) && (c == w - 1), r == rows - 1});
      end
      if (pe && w > 0) sb_q.push_back({8'h00, 1'b1, r == rows - 1});
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    start         = 1'b0;
    i_pix_ready   = 1'b1;
    force_empty   = 1'b0;
    cfg_row_width = '0;
    cfg_row_num   = '0;
`ifdef FEATURE_ROW_READER_PAD_EN
    cfg_pad_en    = 1'b0;
`endif
    sb_q.delete();
    repeat (2) @(posedge system_clk);
    #1;
    n_rden = 0; n_bub = 0; n_done = 0; n_pop = 0;
    first_pop = 0; last_pop = 0; done_cyc = 0;
    rst_n = 1'b1;
  endtask

  // Leaves the bench in cycle 1 (just after the edge that sampled start).
  task automatic start_frame(input int w, input int rows, input bit pe);
    @(posedge system_clk); #1;
    cfg_row_width = 10'(w);
    cfg_row_num   = 10'(rows);
`ifdef FEATURE_ROW_READER_PAD_EN
    cfg_pad_en    = pe;
`endif
    start = 1'b1;
    push_frame(w, rows, pe);
    @(posedge system_clk); #1;
    start = 1'b0;
    c1 = cyc;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge system_clk); #1;
      if (toggle) i_pix_ready = ~i_pix_ready;
      if (n_done != 0) begin
        to = 1'b0;
        break;
      end
    end
    i_pix_ready = 1'b1;
    repeat (3) @(posedge system_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; i_pix_ready = 1'b1; force_empty = 1'b0;
    cfg_row_width = '0; cfg_row_num = '0;
    #3;
    total++;
    if ({busy, done, fifo_rden, fifo_push_bubble} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b required 0000", {busy, done, fifo_rden, fifo_push_bubble});
    end
    total++;
    if (fifo_bubble_num !== 10'd0) begin
      bad++; $display("FAIL reset_bubble_num: got %0d required 0", fifo_bubble_num);
    end
    total++;
    if ({o_pix_valid, o_pix_data, o_pix_last_col, o_pix_last_row} !== 11'd0) begin
      bad++; $display("FAIL reset_pix: got %h required 0", {o_pix_valid, o_pix_data, o_pix_last_col, o_pix_last_row});
    end
    do_reset();
    repeat (2) @(posedge system_clk);
    #1;
    total++;
    if ({busy, done, o_pix_valid} !== 3'b0) begin
      bad++; $display("FAIL idle_after_reset: got %b required 000", {busy, done, o_pix_valid});
    end
  endtask

  task automatic test_basic();
    bit to;
    do_reset();
    wr_cnt = 32; exp_bub = 0;
    start_frame(16, 2, 1'b0);
    total++;
    if (busy !== 1'b1 || fifo_rden !== 1'b1) begin
      bad++; $display("FAIL cycle1: busy=%b rden=%b required 1 1", busy, fifo_rden);
    end
    @(posedge system_clk); #1;
    total++;
    if (o_pix_valid !== 1'b0) begin
      bad++; $display("FAIL cycle2_valid: got %b required 0", o_pix_valid);
    end
    @(posedge system_clk); #1;
    total++;
    if (o_pix_valid !== 1'b1) begin
      bad++; $display("FAIL cycle3_valid: got %b required 1", o_pix_valid);
    end
    wait_done(300, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout: done=0 required 1"); end
    total++;
    if (sb_q.size() != 0 || n_pop != 32) begin
      bad++; $display("FAIL basic_count: left=%0d popped=%0d required 0 32", sb_q.size(), n_pop);
    end
    total++;
    if (first_pop - c1 != 2 || last_pop - first_pop != 31) begin
      bad++; $display("FAIL basic_rate: first=+%0d span=%0d required +2 31", first_pop - c1, last_pop - first_pop);
    end
    total++;
    if (n_bub != 0 || n_done != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_end: bub=%0d done=%0d busy=%b required 0 1 0", n_bub, n_done, busy);
    end
  endtask

  task automatic test_bubble();
    bit to;
    do_reset();
    wr_cnt = 48; exp_bub = 11;
    start_frame(5, 3, 1'b0);
    wait_done(300, 1'b0, to);
    total++;
    if (to || sb_q.size() != 0) begin
      bad++; $display("FAIL bubble_frame: timeout=%b left=%0d required 0 0", to, sb_q.size());
    end
    total++;
    if (n_bub != 3 || n_rden != 15 || n_done != 1) begin
      bad++; $display("FAIL bubble_counts: bub=%0d rden=%0d done=%0d required 3 15 1", n_bub, n_rden, n_done);
    end
  endtask

  task automatic test_ready_toggle();
    bit to;
    do_reset();
    wr_cnt = 32; exp_bub = 0;
    start_frame(16, 2, 1'b0);
    wait_done(400, 1'b1, to);
    total++;
    if (to || sb_q.size() != 0 || n_pop != 32) begin
      bad++; $display("FAIL toggle_frame: timeout=%b left=%0d popped=%0d required 0 0 32", to, sb_q.size(), n_pop);
    end
    total++;
    if (n_rden != 32 || n_done != 1) begin
      bad++; $display("FAIL toggle_counts: rden=%0d done=%0d required 32 1", n_rden, n_done);
    end
  endtask

  task automatic test_empty_stall();
    int stall, snap;
    bit to, checked;
    do_reset();
    wr_cnt = 16; exp_bub = 0;
    stall = 0; snap = 0; checked = 1'b0; to = 1'b1;
    start_frame(16, 1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(posedge system_clk); #1;
      if (n_rden >= 6 && stall < 10) begin
        if (stall == 0) snap = n_rden;
        force_empty = 1'b1;
        stall++;
      end else begin
        if (stall == 10 && !checked) begin
          checked = 1'b1;
          total++;
          if (n_rden != snap) begin
            bad++; $display("FAIL stall_rden: reads during empty=%0d required 0", n_rden - snap);
          end
        end
        force_empty = 1'b0;
      end
      if (n_done != 0) begin to = 1'b0; break; end
    end
    force_empty = 1'b0;
    repeat (2) @(posedge system_clk);
    #1;
    total++;
    if (to || !checked || sb_q.size() != 0) begin
      bad++; $display("FAIL stall_frame: timeout=%b stalled=%b left=%0d required 0 1 0", to, checked, sb_q.size());
    end
    total++;
    if (n_rden != 16 || n_done != 1) begin
      bad++; $display("FAIL stall_counts: rden=%0d done=%0d required 16 1", n_rden, n_done);
    end
  endtask

  task automatic test_zero_and_busy();
    bit to;
    do_reset();
    wr_cnt = 64; exp_bub = 0;
    start_frame(0, 3, 1'b0);
    wait_done(50, 1'b0, to);
    total++;
    if (to || done_cyc - c1 != 1 || n_rden != 0) begin
      bad++; $display("FAIL zero_width: timeout=%b done_at=+%0d rden=%0d required 0 +1 0", to, done_cyc - c1, n_rden);
    end
    do_reset();
    start_frame(16, 1, 1'b0);
    repeat (3) @(posedge system_clk);
    #1;
    cfg_row_width = 10'd5; cfg_row_num = 10'd3; start = 1'b1;
    @(posedge system_clk); #1;
    start = 1'b0;
    wait_done(300, 1'b0, to);
    total++;
    if (to || sb_q.size() != 0 || n_rden != 16) begin
      bad++; $display("FAIL busy_ignore: timeout=%b left=%0d rden=%0d required 0 0 16", to, sb_q.size(), n_rden);
    end
    total++;
    if (n_bub != 0 || n_done != 1) begin
      bad++; $display("FAIL busy_ignore_end: bub=%0d done=%0d required 0 1", n_bub, n_done);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    wr_cnt = 32; exp_bub = 0;
    start_frame(16, 2, 1'b0);
    repeat (8) @(posedge system_clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, o_pix_valid, fifo_rden, done} !== 4'b0) begin
      bad++; $display("FAIL midframe_reset: got %b required 0000", {busy, o_pix_valid, fifo_rden, done});
    end
    sb_q.delete();
    repeat (2) @(posedge system_clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge system_clk);
    #1;
    total++;
    if (n_done != 0 || o_pix_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL after_reset: done=%0d valid=%b busy=%b required 0 0 0", n_done, o_pix_valid, busy);
    end
  endtask

`ifdef FEATURE_ROW_READER_PAD_EN
  task automatic test_pad();
    bit to;
    do_reset();
    wr_cnt = 16; exp_bub = 13;
    start_frame(3, 1, 1'b1);
    wait_done(200, 1'b0, to);
    total++;
    if (to || sb_q.size() != 0 || n_pop != 5) begin
      bad++; $display("FAIL pad_frame: timeout=%b left=%0d popped=%0d required 0 0 5", to, sb_q.size(), n_pop);
    end
    total++;
    if (n_bub != 1 || n_rden != 3) begin
      bad++; $display("FAIL pad_counts: bub=%0d rden=%0d required 1 3", n_bub, n_rden);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) fifo_mem[i] = 8'(i);
    wr_cnt = 0;
    exp_bub = 0;
    c1 = 0;
    test_reset();
    test_basic();
    test_bubble();
    test_ready_toggle();
    test_empty_stall();
    test_zero_and_busy();
    test_midframe_reset();
`ifdef FEATURE_ROW_READER_PAD_EN
    test_pad();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/feature_row_reader.md
# feature_row_reader

Downstream consumer of the feature-buffer FIFO. It reads 8-bit feature pixels row by row from the FIFO's 128-bit-write / 8-bit-read port and presents them as a ready/valid pixel stream to the convolution window builder. Rows are stored 16-pixel aligned, so after each row the block skips the unused tail of the last 128-bit word with `push_bubble`. The stream carries end-of-row and end-of-frame markers.

## Interface
- `MAX_W`, 10: width of row-width, row-count and bubble-count fields.
- `OBUF_DEPTH`, 2: output skid-buffer entries; fixed at 2.
- `system_clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; latches config when idle.
- `cfg_row_width`  in  10  pixels per row (0..1023).
- `cfg_row_num`  in  10  rows per frame (0..1023).
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse at end of frame.
- `fifo_rden`  out  1  FIFO read enable.
- `fifo_rddata`  in  8  FIFO registered read data; valid the cycle after `fifo_rden`.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_push_bubble`  out  1  FIFO read-pointer skip.
- `fifo_bubble_num`  out  10  skip count, valid with `fifo_push_bubble`.
- `o_pix_valid`  out  1  output pixel valid.
- `o_pix_data`  out  8  output pixel.
- `o_pix_last_col`  out  1  last pixel of a row.
- `o_pix_last_row`  out  1  pixel belongs to the last row.
- `i_pix_ready`  in  1  downstream ready.

## Operation
- Config latching: `start` is accepted only in IDLE; it latches the config. `start` while `busy` is ignored.
- Row padding: `pad = (16 - cfg_row_width[3:0]) & 4'hF`, zero-extended to 10 bits.
- States: IDLE, READ, BUBBLE, DRAIN.
- IDLE:
  - on accepted `start`, go to READ;
  - if width or rows = 0, go to DRAIN instead, so `done` is issued with no reads.
- READ:
  - `fifo_rden = !fifo_empty && (occ + inflight - pop) < 2`, where `occ` = skid-buffer occupancy, `inflight` = `fifo_rden` registered, `pop` = `o_pix_valid && i_pix_ready`;
  - column counter increments on each rden;
  - rden with col = width-1 clears col, increments row, and tags the pixel `last_col`;
  - then go to BUBBLE if pad ≠ 0, else READ for the next row, or DRAIN after the last row.
- BUBBLE: exactly one cycle of `fifo_push_bubble=1`, `fifo_bubble_num=pad`, `fifo_rden=0`; then READ or DRAIN. `push_bubble` and `rden` are never high in the same cycle.
- DRAIN: wait until `occ=0` and `inflight=0`, pulse `done`, go to IDLE.
- Tag pipeline: `last_col`/`last_row` are computed at rden time and delayed one cycle alongside `fifo_rddata` into the skid buffer.
- Skid buffer: 2-entry FIFO; it never overflows and never drops data under any `i_pix_ready` pattern.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; skid buffer empty.
- Latency, with `start` sampled at edge 0 and FIFO non-empty:
  - `busy` and `fifo_rden` are high in cycle 1;
  - data is captured in cycle 2;
  - `o_pix_valid` is high in cycle 3.
- Throughput: 1 pixel/cycle with `i_pix_ready` held high, plus one BUBBLE cycle per row when pad ≠ 0.
- Output handshake: `o_pix_*` are held stable while `valid && !ready`.
- Reset mid-frame: immediate return to the reset state, no `done`. The FIFO is reset by the same `rst_n`.
- Empty FIFO in READ: stall with `rden=0`; no timeout.
- Width 16k (pad=0): no BUBBLE cycle.

## Configuration
- `FEATURE_ROW_READER_PAD_EN`: when defined, adds input `cfg_pad_en` (1 bit), latched on `start`.
  - With `cfg_pad_en=1`, every row is emitted as width+2 pixels: a 0x00 before and a 0x00 after the FIFO pixels.
  - These pad pixels are inserted by two extra states, PAD_L before READ and PAD_R after the last read of the row (after the skid buffer drains that row's data); they are not read from the FIFO.
  - `last_col` is carried only by the trailing 0x00.
- When the macro is undefined, the port and states are absent and behaviour equals `cfg_pad_en=0`.

## Test plan
- Width 16, rows 2, FIFO preloaded 0..31, ready=1 → 32 pixels 0..31 in consecutive cycles; `last_col` on 15 and 31; `last_row` on 16..31; no `push_bubble`; `done` once.
- Width 5, rows 3, FIFO 48 entries → per row, 5 reads then one `push_bubble` with `bubble_num`=11; outputs 0–4, 16–20, 32–36.
- Width 16, `i_pix_ready` toggling 1/0 each cycle → no lost or duplicated pixel; `occ` never exceeds 2; data stable while stalled.
- FIFO empty for 10 cycles mid-row → `fifo_rden` stays 0, row resumes, counts correct.
- `start` with width 0 → `done` 1 cycle after DRAIN entry, zero rden; `start` while `busy` → ignored.
- With `FEATURE_ROW_READER_PAD_EN`, `cfg_pad_en=1`, width 3 → row = 0x00, p0, p1, p2, 0x00 with `last_col` on the final 0x00; `bubble_num`=13.
